// File: rtl/lcd_view_pkg.sv
// Shared codes for the LCD view scheduler: mood, indicator and sleep
// encodings seen by the LCD character driver, plus the scheduler state enum.
package lcd_view_pkg;

    localparam logic [1:0] MOOD_SAD     = 2'b00;
    localparam logic [1:0] MOOD_HAPPY   = 2'b01;
    localparam logic [1:0] MOOD_NEUTRAL = 2'b10;

    localparam logic [1:0] IND_HEALTH = 2'b00;
    localparam logic [1:0] IND_ENERGY = 2'b01;
    localparam logic [1:0] IND_FUN    = 2'b11;
    localparam logic [1:0] IND_FOOD   = 2'b10;

    localparam logic [1:0] SLP_NORMAL = 2'b00;
    localparam logic [1:0] SLP_ASLEEP = 2'b01;
    localparam logic [1:0] SLP_DEAD   = 2'b11;

    typedef enum logic [1:0] {
        ST_ROTATE = 2'd0,
        ST_ALERT  = 2'd1,
        ST_SLEEP  = 2'd2,
        ST_DEAD   = 2'd3
    } view_state_e;

    // Rotation index (0 health, 1 energy, 2 fun, 3 food) to indicator code.
    function automatic logic [1:0] idx_to_code(input logic [1:0] idx);
        logic [1:0] code;
        case (idx)
            2'd0:    code = IND_HEALTH;
            2'd1:    code = IND_ENERGY;
            2'd2:    code = IND_FUN;
            default: code = IND_FOOD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/lcd_mood_encode.sv
// Combinational level-to-mood classifier.
// Ports: i_level  - need level being displayed
//        o_mood_c - mood code (happy >= HAPPY_TH, sad <= SAD_TH, else neutral)
module lcd_mood_encode
    import lcd_view_pkg::*;
#(
    parameter int unsigned LEVEL_W  = 3,
    parameter int unsigned HAPPY_TH = 5,
    parameter int unsigned SAD_TH   = 2
) (
    input  logic [LEVEL_W-1:0] i_level,
    output logic [1:0]         o_mood_c
);

    always_comb begin
        o_mood_c = MOOD_NEUTRAL;
        if (i_level >= LEVEL_W'(HAPPY_TH)) begin
            o_mood_c = MOOD_HAPPY;
        end else if (i_level <= LEVEL_W'(SAD_TH)) begin
            o_mood_c = MOOD_SAD;
        end
    end

endmodule

// File: rtl/lcd_view_scheduler.sv
// Chooses the pet LCD view: rotates the four need indicators, pre-empted by
// critical levels, sleep and death. The chosen view is committed only on the
// LCD driver's frame boundary so a frame never mixes two views.
// Ports: clk, reset (async, active-high), tick (dwell pacing strobe),
//        health/energy/fun/food (need levels), sleeping, dead,
//        frame_done (driver end-of-frame pulse),
//        select_figures [3:2] mood [1:0] indicator, sleep (00/01/11),
//        view_update (pulse on committed change), alert (committed ALERT).
module lcd_view_scheduler
    import lcd_view_pkg::*;
#(
    parameter int unsigned LEVEL_W     = 3,
    parameter int unsigned DWELL_TICKS = 4,
    parameter int unsigned HAPPY_TH    = 5,
    parameter int unsigned SAD_TH      = 2,
    parameter int unsigned ALERT_TH    = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic [LEVEL_W-1:0] health,
    input  logic [LEVEL_W-1:0] energy,
    input  logic [LEVEL_W-1:0] fun,
    input  logic [LEVEL_W-1:0] food,
    input  logic               sleeping,
    input  logic               dead,
    input  logic               frame_done,
    output logic [3:0]         select_figures,
    output logic [1:0]         sleep,
    output logic               view_update,
    output logic               alert
);

    localparam int unsigned CNT_W = $clog2(DWELL_TICKS + 1);

    view_state_e        r_state;
    view_state_e        w_state_nxt;
    logic [1:0]         r_idx;
    logic [1:0]         w_idx_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    logic [LEVEL_W-1:0] w_min_lvl;
    logic [1:0]         w_crit_code;
    logic               w_any_crit;
    logic [LEVEL_W-1:0] w_rot_lvl;
    logic [1:0]         w_rot_mood;
    logic [3:0]         w_pend_sf;
    logic [1:0]         w_pend_sleep;
    logic               w_pend_alert;

    // Lowest level wins; strict compares in health, food, energy, fun order
    // keep the earlier indicator on ties. Any level is critical iff the
    // minimum is.
    always_comb begin
        w_min_lvl   = health;
        w_crit_code = IND_HEALTH;
        if (food < w_min_lvl) begin
            w_min_lvl   = food;
            w_crit_code = IND_FOOD;
        end
        if (energy < w_min_lvl) begin
            w_min_lvl   = energy;
            w_crit_code = IND_ENERGY;
        end
        if (fun < w_min_lvl) begin
            w_min_lvl   = fun;
            w_crit_code = IND_FUN;
        end
    end

    assign w_any_crit = (w_min_lvl <= LEVEL_W'(ALERT_TH));

    // Level of the indicator at the rotation index.
    always_comb begin
        case (r_idx)
            2'd0:    w_rot_lvl = health;
            2'd1:    w_rot_lvl = energy;
            2'd2:    w_rot_lvl = fun;
            default: w_rot_lvl = food;
        endcase
    end

    lcd_mood_encode #(
        .LEVEL_W  (LEVEL_W),
        .HAPPY_TH (HAPPY_TH),
        .SAD_TH   (SAD_TH)
    ) u_mood (
        .i_level  (w_rot_lvl),
        .o_mood_c (w_rot_mood)
    );

    // State, rotation index and dwell counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_ROTATE;
            r_idx   <= 2'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state by priority dead > sleeping > critical > rotation. The dwell
    // counter only runs while staying in ROTATE; any state change clears it
    // and drops a coincident tick. The index is kept outside ROTATE.
    always_comb begin
        w_state_nxt = ST_ROTATE;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = '0;
        if (r_state == ST_DEAD || dead) begin
            w_state_nxt = ST_DEAD;
        end else if (sleeping) begin
            w_state_nxt = ST_SLEEP;
        end else if (w_any_crit) begin
            w_state_nxt = ST_ALERT;
        end
        if (r_state == ST_ROTATE && w_state_nxt == ST_ROTATE) begin
            w_cnt_nxt = r_cnt;
            if (tick) begin
                if (r_cnt == CNT_W'(DWELL_TICKS - 1)) begin
                    w_cnt_nxt = '0;
                    w_idx_nxt = r_idx + 2'd1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Pending view derived from the current state only.
    always_comb begin
        w_pend_sf    = {w_rot_mood, idx_to_code(r_idx)};
        w_pend_sleep = SLP_NORMAL;
        w_pend_alert = 1'b0;
        case (r_state)
            ST_ALERT: begin
                w_pend_sf    = {MOOD_SAD, w_crit_code};
                w_pend_alert = 1'b1;
            end
            ST_SLEEP: begin
                w_pend_sf    = select_figures;
                w_pend_sleep = SLP_ASLEEP;
            end
            ST_DEAD: begin
                w_pend_sf    = 4'b0000;
                w_pend_sleep = SLP_DEAD;
            end
            default: ;
        endcase
    end

    // Commit the pending view on the driver's frame boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            select_figures <= {MOOD_NEUTRAL, IND_HEALTH};
            sleep          <= SLP_NORMAL;
            view_update    <= 1'b0;
            alert          <= 1'b0;
        end else begin
            view_update <= 1'b0;
            if (frame_done) begin
                select_figures <= w_pend_sf;
                sleep          <= w_pend_sleep;
                alert          <= w_pend_alert;
                view_update    <= ({w_pend_sf, w_pend_sleep} != {select_figures, sleep});
            end
        end
    end

endmodule

// File: tb/tb_lcd_view_scheduler.sv
// Scoreboard bench for lcd_view_scheduler: a behavioural model pushes the
// expected committed view on every frame_done; a negedge monitor pops it in
// the following output cycle and otherwise expects the outputs to hold.
module tb_lcd_view_scheduler;

    localparam int LEVEL_W = 3;
    localparam int DWELL   = 4;
    localparam int HAPPY   = 5;
    localparam int SAD     = 2;
    localparam int CRIT    = 1;

    logic               clk        = 1'b0;
    logic               reset      = 1'b1;
    logic               tick       = 1'b0;
    logic               sleeping   = 1'b0;
    logic               dead       = 1'b0;
    logic               frame_done = 1'b0;
    logic [LEVEL_W-1:0] health     = 3'd6;
    logic [LEVEL_W-1:0] energy     = 3'd6;
    logic [LEVEL_W-1:0] fun        = 3'd6;
    logic [LEVEL_W-1:0] food       = 3'd6;
    logic [3:0]         select_figures;
    logic [1:0]         sleep;
    logic               view_update;
    logic               alert;

    lcd_view_scheduler #(
        .LEVEL_W     (LEVEL_W),
        .DWELL_TICKS (DWELL),
        .HAPPY_TH    (HAPPY),
        .SAD_TH      (SAD),
        .ALERT_TH    (CRIT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .tick           (tick),
        .health         (health),
        .energy         (energy),
        .fun            (fun),
        .food           (food),
        .sleeping       (sleeping),
        .dead           (dead),
        .frame_done     (frame_done),
        .select_figures (select_figures),
        .sleep          (sleep),
        .view_update    (view_update),
        .alert          (alert)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] sf;
        logic [1:0] sl;
        logic       al;
        logic       vu;
    } view_t;

    localparam view_t RESET_VIEW = '{sf: 4'b1000, sl: 2'b00, al: 1'b0, vu: 1'b0};

    view_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Pacing generator: periodic or random tick, periodic frame_done.
    int cyc       = 0;
    int tick_per  = 10;
    int fd_per    = 3;
    bit fd_en     = 1'b1;
    bit tick_rand = 1'b0;

    always @(negedge clk) begin
        cyc++;
        tick       = tick_rand ? ($urandom_range(0, 3) == 0) : (cyc % tick_per == 0);
        frame_done = fd_en && (cyc % fd_per == 0);
    end

    // ---------------- behavioural reference model ----------------
    // mode: 0 rotate, 1 alert, 2 sleep, 3 dead
    int         m_mode = 0;
    int         m_idx  = 0;
    int         m_cnt  = 0;
    logic [3:0] m_sf   = 4'b1000;
    logic [1:0] m_sl   = 2'b00;
    int         lv[4];
    int         tie_order[4] = '{0, 3, 1, 2};
    int         best;
    int         nxt;
    bit         crit;
    view_t      pend;

    function automatic int mood_of(input int lvl);
        if (lvl >= HAPPY) return 1;
        if (lvl <= SAD)   return 0;
        return 2;
    endfunction

    // Rotation index -> indicator code (health 00, energy 01, fun 11, food 10).
    function automatic int code_of(input int idx);
        case (idx)
            0:       return 0;
            1:       return 1;
            2:       return 3;
            default: return 2;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = 0;
            m_idx  = 0;
            m_cnt  = 0;
            m_sf   = 4'b1000;
            m_sl   = 2'b00;
            exp_q.delete();
        end else begin
            lv[0] = int'(health);
            lv[1] = int'(energy);
            lv[2] = int'(fun);
            lv[3] = int'(food);
            best = tie_order[0];
            for (int i = 1; i < 4; i++) begin
                if (lv[tie_order[i]] < lv[best]) best = tie_order[i];
            end
            crit = (lv[best] <= CRIT);

            if (frame_done) begin
                pend.al = 1'b0;
                pend.sl = 2'b00;
                case (m_mode)
                    0: pend.sf = 4'(mood_of(lv[m_idx]) * 4 + code_of(m_idx));
                    1: begin
                        pend.sf = 4'(code_of(best));
                        pend.al = 1'b1;
                    end
                    2: begin
                        pend.sf = m_sf;
                        pend.sl = 2'b01;
                    end
                    default: begin
                        pend.sf = 4'b0000;
                        pend.sl = 2'b11;
                    end
                endcase
                pend.vu = ({pend.sf, pend.sl} != {m_sf, m_sl});
                exp_q.push_back(pend);
                m_sf = pend.sf;
                m_sl = pend.sl;
            end

            if (m_mode == 3 || dead) nxt = 3;
            else if (sleeping)       nxt = 2;
            else if (crit)           nxt = 1;
            else                     nxt = 0;

            if (nxt != m_mode) begin
                m_cnt = 0;
            end else if (nxt == 0 && tick) begin
                m_cnt++;
                if (m_cnt == DWELL) begin
                    m_cnt = 0;
                    m_idx = (m_idx + 1) % 4;
                end
            end
            m_mode = nxt;
        end
    end

    // ---------------- monitor ----------------
    view_t last = RESET_VIEW;

    always @(negedge clk) begin
        view_t got;
        view_t want;
        if (reset) begin
            last = RESET_VIEW;
        end else begin
            if (exp_q.size() > 0) begin
                want    = exp_q.pop_front();
                last    = want;
                last.vu = 1'b0;
            end else begin
                want = last;
            end
            got = '{sf: select_figures, sl: sleep, al: alert, vu: view_update};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL view @%0t: got sf=%b sleep=%b alert=%b vu=%b, expected sf=%b sleep=%b alert=%b vu=%b",
                         $time, got.sf, got.sl, got.al, got.vu, want.sf, want.sl, want.al, want.vu);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reset asserted between frame_done pulses must clear outputs at once.
    task automatic reset_mid_frame();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({select_figures, sleep, alert, view_update} !== RESET_VIEW) begin
            n_bad++;
            $display("FAIL async_reset: got sf=%b sleep=%b alert=%b vu=%b, expected 1000/00/0/0",
                     select_figures, sleep, alert, view_update);
        end
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic rand_level();
        case ($urandom_range(0, 3))
            0:       health = 3'($urandom_range(0, 7));
            1:       energy = 3'($urandom_range(0, 7));
            2:       fun    = 3'($urandom_range(0, 7));
            default: food   = 3'($urandom_range(0, 7));
        endcase
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;

        // Plain rotation with wrap, levels all happy.
        run(340);

        // Neutral then sad energy while rotating.
        energy = 3'd3;
        run(170);
        energy = 3'd2;
        run(170);
        energy = 3'd6;
        run(40);

        // Critical food and health tie, then recovery.
        food   = 3'd1;
        health = 3'd1;
        run(30);
        health = 3'd4;
        run(30);
        food   = 3'd4;
        run(60);

        // Sleep with starving pet, then wake into ALERT.
        food     = 3'd0;
        sleeping = 1'b1;
        run(30);
        sleeping = 1'b0;
        run(30);
        food = 3'd6;
        run(30);

        // No frame boundary for 50 clk: outputs must stay frozen.
        fd_en = 1'b0;
        repeat (50) begin
            @(negedge clk);
            rand_level();
        end
        fd_en = 1'b1;
        run(20);

        // Randomised phase.
        tick_rand = 1'b1;
        repeat (3000) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0)   rand_level();
            if ($urandom_range(0, 99) == 0)  sleeping = ~sleeping;
            if ($urandom_range(0, 199) == 0) fd_per = $urandom_range(1, 5);
        end
        tick_rand = 1'b0;
        sleeping  = 1'b0;
        fd_per    = 3;
        health    = 3'd6;
        energy    = 3'd6;
        fun       = 3'd6;
        food      = 3'd6;
        run(30);

        // Death is absorbing until reset.
        dead = 1'b1;
        run(2);
        dead = 1'b0;
        run(40);
        reset_mid_frame();
        run(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lcd_view_scheduler.md
# lcd_view_scheduler

Decides what the pet LCD shows and when. It rotates the four need indicators (health, energy, fun, food) and derives the cat's mood from the indicator on screen. Critical levels, sleep and death pre-empt the rotation. The chosen view drives the `select_figures` and `sleep` inputs of the LCD character driver, and changes only at that driver's frame boundary so a frame never mixes two views.

## Interface
- `LEVEL_W`, 3: width of each need level (0 = empty, 2^LEVEL_W-1 = full).
- `DWELL_TICKS`, 4: `tick` pulses each indicator stays on screen in rotation (≥1).
- `HAPPY_TH`, 5: a level ≥ this shows the happy cat.
- `SAD_TH`, 2: a level ≤ this shows the sad cat. A level between `SAD_TH` and `HAPPY_TH` shows neutral.
- `ALERT_TH`, 1: a level ≤ this is critical (`ALERT_TH` < `SAD_TH` < `HAPPY_TH`).
- `clk` input, 1 bit: system clock.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `tick` input, 1 bit: one-cycle pacing strobe that sets dwell time.
- `health`, `energy`, `fun`, `food` inputs, `LEVEL_W` bits each: current need levels.
- `sleeping` input, 1 bit: pet is asleep.
- `dead` input, 1 bit: pet has died.
- `frame_done` input, 1 bit: one-cycle pulse from the LCD driver at the end of a full draw-plus-wait frame.
- `select_figures` output, 4 bits: [3:2] mood (00 sad, 01 happy, 10 neutral), [1:0] indicator (00 health, 01 energy, 11 fun, 10 food).
- `sleep` output, 2 bits: 00 normal, 01 sleeping, 11 dead.
- `view_update` output, 1 bit: one-cycle pulse when a committed view differs from the previous one.
- `alert` output, 1 bit: high while in ALERT. Registered, with the same commit timing as `select_figures`.

## Operation
- States: ROTATE, ALERT, SLEEP, DEAD. Reset enters ROTATE with index 0 (health) and the dwell counter at 0.
- Priority each cycle: `dead` > `sleeping` > any critical level > rotation.
- DEAD is absorbing. Entered when `dead`=1 is sampled. Only `reset` leaves it. Pending view: `sleep`=11, `select_figures` = 4'b0000.
- SLEEP: held while `sleeping`=1 and not dead. Pending view: `sleep`=01, `select_figures` unchanged from the last committed value. When `sleeping` falls, go to ALERT if any level is critical, else ROTATE. The dwell counter clears in both cases.
- ALERT: entered when any level ≤ `ALERT_TH`. Shows the critical indicator with the sad mood (00).
  - Ties break in the order health, food, energy, fun. The lowest level wins first, then tie order.
  - When no level is critical, return to ROTATE at the saved rotation index, with the dwell counter cleared.
- ROTATE:
  - The dwell counter increments on `tick`.
  - On `tick` with the counter at `DWELL_TICKS`-1, the index advances in the order 0 health → 1 energy → 2 fun → 3 food → 0, and the counter clears.
  - Mood comes from the displayed indicator's own level via the thresholds.
- Index-to-code map: health 00, energy 01, fun 11, food 10.
- Pending view is combinational from the state, index and levels. Mid-frame changes to levels are only tracked, never shown.

## Timing
- Reset values: `select_figures` = 4'b1000 (neutral, health), `sleep` = 00, `view_update` = 0, `alert` = 0.
- Commit: on the cycle `frame_done`=1, the pending view is registered. Outputs change on the next cycle; latency is 1 clk from `frame_done`.
- `view_update` pulses high in that same output cycle if `{select_figures, sleep}` changed, and is 0 otherwise.
- Before the first `frame_done` after reset, outputs hold their reset values.
- State transitions take effect 1 clk after the input is sampled.
- A `tick` in the same cycle as a state change is ignored, and the counter clears.
- `frame_done` in the same cycle as a state change commits the view of the old state.
- `reset` asserted mid-frame clears all state and outputs immediately and asynchronously. It wins over `frame_done` and `tick`.
- Level comparisons are unsigned, `LEVEL_W` bits. The dwell counter width is $clog2(DWELL_TICKS+1), with no overflow.

## Structure
- Shared package `lcd_view_pkg` holds:
  - the mood codes (SAD 2'b00, HAPPY 2'b01, NEUTRAL 2'b10);
  - the indicator codes (HEALTH 2'b00, ENERGY 2'b01, FUN 2'b11, FOOD 2'b10);
  - the sleep codes (NORMAL 2'b00, ASLEEP 2'b01, DEAD 2'b11);
  - the state enum.
- One sub-module, `lcd_mood_encode`: a combinational level-to-mood classifier parameterised by the thresholds, instantiated once for the displayed level.

## Test plan
- Levels all 6, `tick` every 10 clk, `frame_done` every 3 clk → `select_figures` steps through 0100, 0101, 0111, 0110 and wraps to 0100, each shown for 4 ticks, with `view_update` pulsing at each change.
- `energy` = 3, others 6, index reaches energy → `select_figures` = 1001 (neutral). With `energy` = 2 → 0001 (sad).
- `food` = 1 and `health` = 1 mid-rotation → `alert` = 1 and `select_figures` = 0000 (health wins the tie). Raise `health` to 4 → 0010. Raise `food` to 4 → rotation resumes at the saved index.
- `sleeping` pulse with `food` = 0 → `sleep` = 01. On release → ALERT shows 0010.
- `dead` = 1, then `dead` = 0 → `sleep` stays 11 and `select_figures` stays 0000 until `reset`. Reset asserted between two `frame_done` pulses → outputs are 1000/00 immediately.
- Level changes with no `frame_done` for 50 clk → outputs frozen. The first `frame_done` commits the latest pending view, one clk later.
